arcabuco_memory_stage: RTL and testbench

Load/store stage of the Arcabuco core, directly downstream of the execution stage. It consumes the ALU result as the effective address, the forwarded store operand as write data, and the execution stage's `memory_access` hint. It runs a single outstanding data-bus transaction, aligning store data into byte lanes and sign- or zero-extending load data. It delivers a registered result to writeback and back-pressures the pipeline with `stall`.

---
 rtl/arcabuco_memory_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_arcabuco_memory_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/arcabuco_memory_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arcabuco_memory_stage: load/store stage with one outstanding data-bus op.
// Revision 1.0
// ----------------------------------------------------------------------------
module arcabuco_memory_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_read,
  input  logic        in_write,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_access,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_load,
  output logic        exc_misaligned,
  output logic        exc_bus
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_FDATA = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic          r_store;
  logic [CW-1:0] r_count;

  logic        w_accept, w_is_mem, w_misaligned, w_fixed_req, w_hs_start;
  logic        w_in_req, w_sel_store, w_timeout;
  logic [31:0] w_sel_addr, w_sel_wdata, w_lane_wdata, w_load_data;
  logic [1:0]  w_sel_size;
  logic [3:0]  w_lane_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_done, w_done_load, w_done_mis, w_done_bus;
  logic [31:0] w_done_data;

  assign stall        = (r_state != S_IDLE);
  assign w_accept     = (r_state == S_IDLE) && in_valid && !rst;
  assign w_is_mem     = in_read | in_write;
  assign w_misaligned = w_is_mem &&
                        (((in_size == 2'b01) && in_addr[0]) ||
                         (in_size[1] && (in_addr[1:0] != 2'b00)));
  assign w_fixed_req  = w_accept && w_is_mem && !w_misaligned && !in_access;
  assign w_hs_start   = w_accept && w_is_mem && !w_misaligned && in_access;
  assign w_timeout    = (TIMEOUT != 0) && (r_count == TLAST);

  // Bus fields come from the held operation in REQ, else from the accept-cycle inputs
  assign w_in_req    = (r_state == S_REQ);
  assign w_sel_addr  = w_in_req ? r_addr  : in_addr;
  assign w_sel_wdata = w_in_req ? r_wdata : in_wdata;
  assign w_sel_size  = w_in_req ? r_size  : in_size;
  assign w_sel_store = w_in_req ? r_store : (in_write & ~in_read);

  always_comb begin
    w_lane_be    = 4'b1111;
    w_lane_wdata = w_sel_wdata;
    case (w_sel_size)
      2'b00: begin
        w_lane_be    = 4'b0001 << w_sel_addr[1:0];
        w_lane_wdata = {4{w_sel_wdata[7:0]}};
      end
      2'b01: begin
        w_lane_be    = w_sel_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{w_sel_wdata[15:0]}};
      end
      default: begin
        w_lane_be    = 4'b1111;
        w_lane_wdata = w_sel_wdata;
      end
    endcase
  end

  assign bus_req   = w_in_req || w_fixed_req;
  assign bus_we    = bus_req && w_sel_store;
  assign bus_addr  = bus_req ? {w_sel_addr[31:2], 2'b00} : 32'h0;
  assign bus_be    = bus_req ? w_lane_be : 4'b0000;
  assign bus_wdata = (bus_req && w_sel_store) ? w_lane_wdata : 32'h0;

  always_comb begin
    w_byte      = bus_rdata[8*r_addr[1:0] +: 8];
    w_half      = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    w_load_data = bus_rdata;
    case (r_size)
      2'b00:   w_load_data = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_data = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_done_data = r_addr;
    w_done_load = 1'b0;
    w_done_mis  = 1'b0;
    w_done_bus  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_is_mem) begin
            w_done      = 1'b1;
            w_done_data = in_addr;
          end else if (w_misaligned) begin
            w_done      = 1'b1;
            w_done_mis  = 1'b1;
            w_done_data = in_addr;
          end else if (in_access) begin
            w_state_nxt = S_REQ;
          end else if (in_read) begin
            w_state_nxt = S_FDATA;
          end else begin
            w_done      = 1'b1;
            w_done_data = in_addr;
          end
        end
      end
      S_REQ: begin
        if (bus_gnt && r_store) begin
          w_done      = 1'b1;
          w_done_bus  = bus_err;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_done      = 1'b1;
          w_done_bus  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus_gnt) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
          if (bus_err) begin
            w_done_bus = 1'b1;
          end else begin
            w_done_data = w_load_data;
            w_done_load = 1'b1;
          end
        end else if (w_timeout) begin
          w_done      = 1'b1;
          w_done_bus  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_FDATA: begin
        w_done      = 1'b1;
        w_done_data = w_load_data;
        w_done_load = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_addr         <= 32'h0;
      r_wdata        <= 32'h0;
      r_size         <= 2'b00;
      r_unsigned     <= 1'b0;
      r_store        <= 1'b0;
      r_count        <= '0;
      out_valid      <= 1'b0;
      out_data       <= 32'h0;
      out_load       <= 1'b0;
      exc_misaligned <= 1'b0;
      exc_bus        <= 1'b0;
    end else begin
      out_valid      <= w_done;
      out_data       <= w_done ? w_done_data : 32'h0;
      out_load       <= w_done_load;
      exc_misaligned <= w_done_mis;
      exc_bus        <= w_done_bus;
      if (w_accept) begin
        r_addr     <= in_addr;
        r_wdata    <= in_wdata;
        r_size     <= in_size;
        r_unsigned <= in_unsigned;
        r_store    <= in_write & ~in_read;
      end
      if (w_hs_start)
        r_count <= '0;
      else if ((r_state == S_REQ) || (r_state == S_WAIT))
        r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arcabuco_memory_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_arcabuco_memory_stage: directed self-checking bench for the memory stage.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_arcabuco_memory_stage;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_read = 1'b0, in_write = 1'b0;
  logic [1:0]  in_size = 2'b00;
  logic        in_unsigned = 1'b0;
  logic [31:0] in_addr = 32'h0, in_wdata = 32'h0;
  logic        in_access = 1'b0;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        out_valid, out_load, exc_misaligned, exc_bus;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  arcabuco_memory_stage #(.TIMEOUT(4)) dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_read(in_read), .in_write(in_write),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_access(in_access),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .out_valid(out_valid), .out_data(out_data), .out_load(out_load),
    .exc_misaligned(exc_misaligned), .exc_bus(exc_bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd, input logic acc);
    in_valid    = 1'b1;
    in_read     = rd;
    in_write    = wr;
    in_size     = sz;
    in_unsigned = uns;
    in_addr     = a;
    in_wdata    = wd;
    in_access   = acc;
  endtask

  initial begin
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_out_data", out_data, 0);
    check("rst_exc_bus", exc_bus, 0);
    rst = 1'b0;
    step();

    // Signed byte load, handshaked, rvalid one cycle late
    op(1, 0, 2'b00, 0, 32'h8000_0003, 0, 1); #1;
    check("sb_accept_noreq", bus_req, 0);
    step(); in_valid = 0; bus_gnt = 1; #1;
    check("sb_req", bus_req, 1);
    check("sb_be", bus_be, 4'b1000);
    check("sb_addr", bus_addr, 32'h8000_0000);
    check("sb_we", bus_we, 0);
    check("sb_stall", stall, 1);
    step(); bus_gnt = 0; #1;
    check("sb_wait_stall", stall, 1);
    check("sb_wait_noreq", bus_req, 0);
    step(); bus_rvalid = 1; bus_rdata = 32'h80AB_CDEF;
    step(); bus_rvalid = 0; #1;
    check("sb_out_valid", out_valid, 1);
    check("sb_out_data", out_data, 32'hFFFF_FF80);
    check("sb_out_load", out_load, 1);
    check("sb_stall_low", stall, 0);

    // Unsigned half load, handshaked
    op(1, 0, 2'b01, 1, 32'h0000_0010, 0, 1);
    step(); in_valid = 0; bus_gnt = 1; #1;
    check("uh_be", bus_be, 4'b0011);
    step(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'hF00D_8001;
    step(); bus_rvalid = 0; #1;
    check("uh_out_valid", out_valid, 1);
    check("uh_out_data", out_data, 32'h0000_8001);
    check("uh_out_load", out_load, 1);

    // Fixed-path half store followed back-to-back by a byte store
    op(0, 1, 2'b01, 0, 32'h0000_0102, 32'h1234_5678, 0); #1;
    check("fh_req", bus_req, 1);
    check("fh_we", bus_we, 1);
    check("fh_wdata", bus_wdata, 32'h5678_5678);
    check("fh_be", bus_be, 4'b1100);
    check("fh_addr", bus_addr, 32'h0000_0100);
    check("fh_stall", stall, 0);
    step(); op(0, 1, 2'b00, 0, 32'h0000_0101, 32'h0000_00AB, 0); #1;
    check("fh_out_valid", out_valid, 1);
    check("fb_stall", stall, 0);
    check("fb_wdata", bus_wdata, 32'hABAB_ABAB);
    check("fb_be", bus_be, 4'b0010);
    step(); in_valid = 0; #1;
    check("fb_out_valid", out_valid, 1);
    check("fb_noreq", bus_req, 0);

    // Fixed-path unsigned byte load
    op(1, 0, 2'b00, 1, 32'h0000_0007, 0, 0); #1;
    check("fl_req", bus_req, 1);
    check("fl_be", bus_be, 4'b1000);
    check("fl_we", bus_we, 0);
    step(); in_valid = 0; bus_rdata = 32'h1234_5678; #1;
    check("fl_stall", stall, 1);
    check("fl_noreq", bus_req, 0);
    step(); #1;
    check("fl_out_valid", out_valid, 1);
    check("fl_out_data", out_data, 32'h0000_0012);
    check("fl_stall_low", stall, 0);

    // Misaligned word load
    op(1, 0, 2'b10, 0, 32'h0000_0006, 0, 1); #1;
    check("mis_noreq", bus_req, 0);
    step(); in_valid = 0; #1;
    check("mis_out_valid", out_valid, 1);
    check("mis_exc", exc_misaligned, 1);
    check("mis_out_data", out_data, 32'h0000_0006);
    check("mis_stall", stall, 0);

    // Timeout on a granted load, then a late rvalid
    op(1, 0, 2'b10, 0, 32'h0000_0020, 0, 1);
    step(); in_valid = 0; bus_gnt = 1;
    step(); bus_gnt = 0;
    step();
    step(); #1;
    check("to_not_yet", out_valid, 0);
    check("to_stall", stall, 1);
    step(); #1;
    check("to_out_valid", out_valid, 1);
    check("to_exc_bus", exc_bus, 1);
    check("to_stall_low", stall, 0);
    bus_rvalid = 1; bus_rdata = 32'hDEAD_0000;
    step(); bus_rvalid = 0; #1;
    check("to_late_ignored", out_valid, 0);
    check("to_late_stall", stall, 0);

    // Handshaked byte store with bus error
    op(0, 1, 2'b00, 0, 32'h0000_0033, 32'h0000_005A, 1);
    step(); in_valid = 0; bus_gnt = 1; bus_err = 1; #1;
    check("be_we", bus_we, 1);
    check("be_be", bus_be, 4'b1000);
    check("be_wdata", bus_wdata, 32'h5A5A_5A5A);
    step(); bus_gnt = 0; bus_err = 0; #1;
    check("be_out_valid", out_valid, 1);
    check("be_exc_bus", exc_bus, 1);
    check("be_out_data", out_data, 32'h0000_0033);

    // Reset in WAIT abandons the load
    op(1, 0, 2'b10, 0, 32'h0000_0040, 0, 1);
    step(); in_valid = 0; bus_gnt = 1;
    step(); bus_gnt = 0; rst = 1; #1;
    check("rm_wait_stall", stall, 1);
    step(); rst = 0; #1;
    check("rm_bus_req", bus_req, 0);
    check("rm_stall", stall, 0);
    check("rm_out_valid", out_valid, 0);

    // Handshaked word store after reset, grant delayed one cycle
    op(0, 1, 2'b10, 0, 32'h0000_0044, 32'hCAFE_F00D, 1);
    step(); in_valid = 0; #1;
    check("ws_req_hold", bus_req, 1);
    step(); bus_gnt = 1; #1;
    check("ws_req_still", bus_req, 1);
    check("ws_addr", bus_addr, 32'h0000_0044);
    check("ws_wdata", bus_wdata, 32'hCAFE_F00D);
    check("ws_be", bus_be, 4'b1111);
    step(); bus_gnt = 0; #1;
    check("ws_out_valid", out_valid, 1);
    check("ws_exc_bus", exc_bus, 0);
    check("ws_out_load", out_load, 0);

    // Non-memory op passes the ALU result through
    op(0, 0, 2'b10, 0, 32'hDEAD_BEEF, 0, 1); #1;
    check("nm_noreq", bus_req, 0);
    step(); in_valid = 0; #1;
    check("nm_out_valid", out_valid, 1);
    check("nm_out_data", out_data, 32'hDEAD_BEEF);
    check("nm_out_load", out_load, 0);
    step(); #1;
    check("nm_pulse_end", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
